// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back, write-allocate cache controller with
// per-set round-robin replacement and saturating hit/miss statistics.
module cache_assoc_wb #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int SETS        = 4,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 4,
    parameter int COUNT_WIDTH = 16,
    localparam int OFF_W  = $clog2(BLOCK_WORDS),
    localparam int BLK_W  = ADDR_WIDTH - OFF_W,
    localparam int LINE_W = BLOCK_WORDS * DATA_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cpu_req_valid,
    input  logic                   cpu_req_write,
    input  logic [ADDR_WIDTH-1:0]  cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_req_wdata,
    output logic                   cpu_req_ready,
    output logic                   cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]  cpu_resp_rdata,
    output logic                   hit_miss,
    output logic                   mem_req_valid,
    output logic                   mem_req_write,
    output logic [BLK_W-1:0]       mem_req_addr,
    output logic [LINE_W-1:0]      mem_req_wdata,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [LINE_W-1:0]      mem_resp_rdata,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count,
    output logic [2:0]             state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; a requester holds valid and its payload until then.
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOC_REQ, ALLOC_WAIT} state_t;
    state_t state, next_state;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  ptr_q   [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];

    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  miss_q;
    logic [WAY_W-1:0]      victim_q;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    assign req_off = req_addr[OFF_W-1:0];
    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];

    logic             hit, inv_found, victim_dirty;
    logic [WAY_W-1:0] hit_way, inv_way, victim;

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim       = inv_found ? inv_way : ptr_q[req_idx];
        victim_dirty = valid_q[req_idx][victim] && dirty_q[req_idx][victim];
    end

    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (cpu_req_valid && cpu_req_ready) next_state = COMPARE;
            COMPARE:    if (hit)               next_state = IDLE;
                        else if (victim_dirty) next_state = WRITEBACK;
                        else                   next_state = ALLOC_REQ;
            WRITEBACK:  if (mem_req_ready)  next_state = ALLOC_REQ;
            ALLOC_REQ:  if (mem_req_ready)  next_state = ALLOC_WAIT;
            ALLOC_WAIT: if (mem_resp_valid) next_state = COMPARE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            req_write      <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            miss_q         <= 1'b0;
            victim_q       <= '0;
            cpu_req_ready  <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            hit_miss       <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_write  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            cpu_req_ready  <= (next_state == IDLE);
            cpu_resp_valid <= 1'b0;
            mem_req_valid  <= (next_state == WRITEBACK) || (next_state == ALLOC_REQ);
            mem_req_write  <= (next_state == WRITEBACK);
            case (state)
                IDLE: if (cpu_req_valid && cpu_req_ready) begin
                    req_write <= cpu_req_write;
                    req_addr  <= cpu_req_addr;
                    req_wdata <= cpu_req_wdata;
                    miss_q    <= 1'b0;
                end
                COMPARE: if (hit) begin
                    cpu_resp_valid <= 1'b1;
                    hit_miss       <= !miss_q;
                    cpu_resp_rdata <= req_write ? req_wdata
                                    : data_q[req_idx][hit_way][req_off*DATA_WIDTH +: DATA_WIDTH];
                    if (req_write) dirty_q[req_idx][hit_way] <= 1'b1;
                    if (miss_q) begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                    end else begin
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                    end
                end else begin
                    miss_q   <= 1'b1;
                    victim_q <= victim;
                    if (!inv_found)
                        ptr_q[req_idx] <= (ptr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0
                                        : ptr_q[req_idx] + 1'b1;
                    if (victim_dirty) begin
                        mem_req_addr  <= {tag_q[req_idx][victim], req_idx};
                        mem_req_wdata <= data_q[req_idx][victim];
                    end else begin
                        mem_req_addr  <= req_addr[ADDR_WIDTH-1:OFF_W];
                    end
                end
                WRITEBACK: if (mem_req_ready) mem_req_addr <= req_addr[ADDR_WIDTH-1:OFF_W];
                ALLOC_WAIT: if (mem_resp_valid) begin
                    valid_q[req_idx][victim_q] <= 1'b1;
                    dirty_q[req_idx][victim_q] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clock) begin
        if (state == COMPARE && hit && req_write)
            data_q[req_idx][hit_way][req_off*DATA_WIDTH +: DATA_WIDTH] <= req_wdata;
        if (state == ALLOC_WAIT && mem_resp_valid) begin
            data_q[req_idx][victim_q] <= mem_resp_rdata;
            tag_q[req_idx][victim_q]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_cache_assoc_wb.sv
// Randomised scoreboard bench for cache_assoc_wb against a behavioural cache
// model with its own backing memory.
module tb_cache_assoc_wb;
    localparam int AW = 10, DW = 32, SETS = 4, WAYS = 2, BW = 4, CW = 2;
    localparam int LW = BW * DW, BLKW = 8;

    logic clock, reset_n;
    logic cpu_req_valid, cpu_req_write, cpu_req_ready, cpu_resp_valid, hit_miss;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata, cpu_resp_rdata;
    logic mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid;
    logic [BLKW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_wdata, mem_resp_rdata;
    logic [CW-1:0] hit_count, miss_count;
    logic [2:0] state_dbg;

    cache_assoc_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETS(SETS), .WAYS(WAYS),
                     .BLOCK_WORDS(BW), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata), .hit_miss(hit_miss),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .hit_count(hit_count),
        .miss_count(miss_count), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int tests = 0, failed = 0;
    logic [36:0]  exp_q[$];      // {hit, rdata, hit_count, miss_count}
    logic [136:0] exp_mem_q[$];  // {write, block addr, line}
    int accept_cyc = 0;
    int stall_wb_cnt = 0;
    int fill_delay_override = -1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_valid[SETS][WAYS];
    logic        m_dirty[SETS][WAYS];
    int          m_tag[SETS][WAYS];
    logic [31:0] m_data[SETS][WAYS][BW];
    int          m_ptr[SETS];
    int          m_hits, m_misses;
    logic [31:0] ref_mem[1024];
    logic [31:0] mem_arr[1024];

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
        int off, idx, tag, way, blk;
        logic hm;
        logic [31:0] rd;
        logic [LW-1:0] line;
        off = int'(a) % BW;
        blk = int'(a) / BW;
        idx = blk % SETS;
        tag = blk / SETS;
        way = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
        hm = (way >= 0);
        if (!hm) begin
            for (int w = 0; w < WAYS; w++)
                if (way < 0 && !m_valid[idx][w]) way = w;
            if (way < 0) begin
                way = m_ptr[idx];
                m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
            end
            if (m_valid[idx][way] && m_dirty[idx][way]) begin
                for (int k = 0; k < BW; k++) begin
                    line[k*DW +: DW] = m_data[idx][way][k];
                    ref_mem[(m_tag[idx][way] * SETS + idx) * BW + k] = m_data[idx][way][k];
                end
                exp_mem_q.push_back({1'b1, 8'(m_tag[idx][way] * SETS + idx), line});
            end
            exp_mem_q.push_back({1'b0, 8'(blk), {LW{1'b0}}});
            for (int k = 0; k < BW; k++) m_data[idx][way][k] = ref_mem[blk * BW + k];
            m_valid[idx][way] = 1'b1;
            m_dirty[idx][way] = 1'b0;
            m_tag[idx][way] = tag;
        end
        if (wr) begin
            m_data[idx][way][off] = d;
            m_dirty[idx][way] = 1'b1;
            rd = d;
        end else begin
            rd = m_data[idx][way][off];
        end
        if (hm) m_hits = (m_hits < 3) ? m_hits + 1 : 3;
        else    m_misses = (m_misses < 3) ? m_misses + 1 : 3;
        exp_q.push_back({hm, rd, 2'(m_hits), 2'(m_misses)});
    endtask

    // ---------------- CPU response monitor ----------------
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clock);
            if (reset_n && cpu_resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", {cpu_resp_rdata, hit_miss}, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_hit_miss", hit_miss, e[36]);
                    check("resp_rdata", cpu_resp_rdata, e[35:4]);
                    check("hit_count", hit_count, e[3:2]);
                    check("miss_count", miss_count, e[1:0]);
                    if (e[36]) check("hit_latency", cyc - accept_cyc, 1);
                end
            end
        end
    end

    // ---------------- memory responder and request checker ----------------
    initial begin
        logic prev_valid, prev_ready, prev_write, pending;
        logic [BLKW-1:0] prev_addr;
        logic [LW-1:0] prev_wdata, pend_line;
        logic [136:0] e;
        int delay;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_write = 1'b0;
        prev_addr = '0; prev_wdata = '0; pend_line = '0; pending = 1'b0; delay = 0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        forever begin
            @(negedge clock);
            if (reset_n && prev_valid && prev_ready) begin
                if (exp_mem_q.size() == 0) begin
                    check("mem_unexpected", {prev_write, prev_addr}, '0);
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_write", prev_write, e[136]);
                    check("mem_addr", prev_addr, e[135:128]);
                    if (e[136]) check("wb_data", prev_wdata, e[127:0]);
                end
                if (prev_write) begin
                    for (int k = 0; k < BW; k++) mem_arr[int'(prev_addr) * BW + k] = prev_wdata[k*DW +: DW];
                end else begin
                    for (int k = 0; k < BW; k++) pend_line[k*DW +: DW] = mem_arr[int'(prev_addr) * BW + k];
                    pending = 1'b1;
                    delay = (fill_delay_override >= 0) ? fill_delay_override : $urandom_range(0, 3);
                end
            end else if (reset_n && prev_valid) begin
                check("req_hold", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata},
                      {1'b1, prev_write, prev_addr, prev_wdata});
            end
            if (reset_n && mem_req_valid) check("stall_ready", cpu_req_ready, 1'b0);
            mem_resp_valid = 1'b0;
            if (pending) begin
                if (delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = pend_line;
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mem_req_valid && mem_req_write && stall_wb_cnt > 0) begin
                mem_req_ready = 1'b0;
                stall_wb_cnt--;
            end else begin
                mem_req_ready = ($urandom_range(0, 3) != 0);
            end
            prev_valid = reset_n && mem_req_valid;
            prev_ready = mem_req_ready;
            prev_write = mem_req_write;
            prev_addr  = mem_req_addr;
            prev_wdata = mem_req_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_req(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
        int budget;
        model_access(wr, a, d);
        @(negedge clock);
        cpu_req_valid = 1'b1;
        cpu_req_write = wr;
        cpu_req_addr  = a;
        cpu_req_wdata = d;
        budget = 0;
        while (!cpu_req_ready && budget < 300) begin
            @(negedge clock);
            budget++;
        end
        if (!cpu_req_ready) begin
            check("accept_timeout", cpu_req_ready, 1'b1);
            cpu_req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        accept_cyc = cyc;
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || !cpu_req_ready) && budget < 500) begin
            @(negedge clock);
            budget++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic logic [255:0] all_outputs();
        return {cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, hit_miss, mem_req_valid,
                mem_req_write, mem_req_addr, mem_req_wdata, hit_count, miss_count, state_dbg};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int budget;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = $urandom;
            mem_arr[i] = ref_mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            ref_mem[4 + i] = 32'h11 * i;
            mem_arr[4 + i] = 32'h11 * i;
        end
        model_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 check("reset_outputs", all_outputs(), '0);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_reset", cpu_req_ready, 1'b1);

        // Cold miss, hits, write hit, eviction order with write-back stall.
        cpu_req(1'b0, 10'h004, 32'h0);
        cpu_req(1'b0, 10'h006, 32'h0);
        cpu_req(1'b1, 10'h005, 32'hDEADBEEF);
        cpu_req(1'b0, 10'h005, 32'h0);
        cpu_req(1'b0, 10'h014, 32'h0);
        wait_idle();
        stall_wb_cnt = 5;
        cpu_req(1'b0, 10'h024, 32'h0);
        cpu_req(1'b0, 10'h034, 32'h0);
        wait_idle();
        check("wb_stall_used", stall_wb_cnt, 0);

        // Reset while waiting for a fill; the late fill must be ignored.
        fill_delay_override = 10;
        cpu_req(1'b0, 10'h104, 32'h0);
        budget = 0;
        while (state_dbg != 3'd4 && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        check("reached_alloc_wait", state_dbg, 3'd4);
        #2 reset_n = 1'b0;
        #1 check("midmiss_reset_outputs", all_outputs(), '0);
        exp_q.delete();
        exp_mem_q.delete();
        model_reset();
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (15) @(negedge clock);
        fill_delay_override = -1;
        check("idle_after_late_fill", {state_dbg, cpu_req_ready}, {3'd0, 1'b1});

        // Re-read misses, then drive counters into saturation.
        cpu_req(1'b0, 10'h004, 32'h0);
        for (int i = 0; i < 5; i++) cpu_req(1'b0, 10'(4 + (i % 4)), 32'h0);
        cpu_req(1'b0, 10'h044, 32'h0);
        cpu_req(1'b0, 10'h084, 32'h0);
        cpu_req(1'b0, 10'h0C4, 32'h0);
        wait_idle();
        check("sat_hit_count", hit_count, 2'd3);
        check("sat_miss_count", miss_count, 2'd3);

        // Randomised traffic biased toward set conflicts.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 127)) : 10'($urandom_range(0, 1023));
            cpu_req($urandom_range(0, 2) == 0, a, $urandom);
        end
        wait_idle();
        repeat (10) @(negedge clock);
        check("mem_queue_drained", exp_mem_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #900000;
        tests++;
        failed++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/cache_assoc_wb.md
# cache_assoc_wb

Parametrised N-way set-associative, write-back, write-allocate cache controller. It sits between the CPU request generator and the block memory in the cache subsystem top, and generalises the direct-mapped cache. It adds configurable sets, ways and block size, dirty-line write-back, per-set round-robin replacement, ready/valid handshakes on both sides, and saturating hit/miss counters.

## Interface
- ADDR_WIDTH, 10: word address width.
- DATA_WIDTH, 32: word width.
- SETS, 4: number of sets; power of two, ≥2.
- WAYS, 2: associativity; power of two, 1..8.
- BLOCK_WORDS, 4: words per line; power of two, ≥2.
- COUNT_WIDTH, 16: width of the statistics counters.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  request present.
- cpu_req_write  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_WIDTH  word address.
- cpu_req_wdata  in  DATA_WIDTH  write data.
- cpu_req_ready  out  1  request accepted on an edge where valid=1 and ready=1.
- cpu_resp_valid  out  1  one-cycle response strobe.
- cpu_resp_rdata  out  DATA_WIDTH  read data; echoes wdata for writes.
- hit_miss  out  1  valid with the response; 1 = hit, 0 = miss.
- mem_req_valid  out  1  memory request.
- mem_req_write  out  1  1 = write-back, 0 = fill.
- mem_req_addr  out  ADDR_WIDTH-log2(BLOCK_WORDS)  block address.
- mem_req_wdata  out  BLOCK_WORDS*DATA_WIDTH  victim line; word 0 in the LSBs.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  fill data valid; one cycle.
- mem_resp_rdata  in  BLOCK_WORDS*DATA_WIDTH  fill line.
- hit_count, miss_count  out  COUNT_WIDTH  saturating statistics.

## Operation
- **Address split:** offset = addr[log2(BLOCK_WORDS)-1:0]; index = next log2(SETS) bits; tag = remaining bits. Block address = addr >> log2(BLOCK_WORDS).
- **State per line:** valid, dirty, tag, data. Each set also holds a round-robin victim pointer.
- **Reset:** clears valid, dirty, pointers, counters and all outputs, and sets the state to IDLE. The data and tag arrays are not reset.
- **FSM states:** IDLE, COMPARE, WRITEBACK, ALLOC_REQ, ALLOC_WAIT.
  - IDLE: cpu_req_ready=1. On accept, register the request and go to COMPARE.
  - COMPARE, hit: a read returns the word. A write updates the word and sets dirty=1. In both cases assert cpu_resp_valid and go to IDLE. hit_miss=1 unless this request already missed.
  - COMPARE, miss: set a sticky miss flag. Select a victim:
    - the lowest-index invalid way, if any;
    - otherwise the way at the set's pointer, and advance the pointer modulo WAYS.
    - Victim valid and dirty → WRITEBACK; otherwise → ALLOC_REQ.
  - WRITEBACK: drive mem_req_valid=1, write=1, addr={victim tag, index}, wdata=victim line. Hold all of these stable until mem_req_ready is sampled high, then go to ALLOC_REQ.
  - ALLOC_REQ: drive mem_req_valid=1, write=0, addr=request block address. On mem_req_ready, go to ALLOC_WAIT.
  - ALLOC_WAIT: on mem_resp_valid, write the line with valid=1, dirty=0 and the new tag, then return to COMPARE. The retry hits and responds with hit_miss=0.
- **Counters:** hit_count increments on each hit response and miss_count on each miss response. Both saturate at all-ones.
- **Ignored inputs:** mem_resp_valid outside ALLOC_WAIT and mem_req_ready outside the request states are ignored.
- **Reset mid-operation:** any in-flight memory transaction is abandoned. No response is ever produced for the interrupted request.

## Timing
- **Hit latency:** accepted at edge T0; cpu_resp_valid is high for the single cycle T1–T2. cpu_req_ready returns high at T1, so the next accept can occur at T2. Peak throughput is one request per 2 cycles.
- **Clean miss:** 1 (COMPARE) + fill handshake + fill wait + 1 (COMPARE retry).
- **Dirty miss:** adds the write-back handshake.
- **Stall:** cpu_req_ready=0 in every state except IDLE.
- **Registered outputs:** all outputs are registered. cpu_resp_rdata and hit_miss are only meaningful while cpu_resp_valid=1.

## Test plan
Defaults: SETS=4, WAYS=2, BLOCK_WORDS=4, ADDR_WIDTH=10. Index is addr[3:2].

- **Cold miss then hit:** after reset, read 0x004.
  - Memory request: mem_req_valid, write=0, addr=0x001.
  - Memory returns {0x33,0x22,0x11,0x00}.
  - Response: rdata=0x00, hit_miss=0.
  - Read 0x006: rdata=0x22, hit_miss=1, resp_valid exactly 1 cycle after accept.
- **Write hit:** write 0xDEADBEEF to 0x005 gives hit_miss=1 and dirty=1. Reading 0x005 returns 0xDEADBEEF with no memory traffic.
- **Eviction order:** with 0x004 dirty, fill 0x014, then read 0x024.
  - Required sequence: write-back addr=0x01 with word1=0xDEADBEEF, then fill addr=0x09.
  - A following read of 0x034 evicts the way-1 line (0x014, clean): fill only, no write-back.
- **Backpressure:** hold mem_req_ready=0 for 5 cycles during WRITEBACK.
  - mem_req_valid, addr and wdata stay constant; cpu_req_ready stays 0.
  - Completion occurs after ready rises.
- **Reset mid-miss:** pulse reset_n low in ALLOC_WAIT.
  - All outputs go to 0 immediately, asynchronously.
  - A late mem_resp_valid is ignored.
  - Re-reading 0x004 misses.
- **Counter saturation:** with COUNT_WIDTH=2, issue 5 hits and 4 misses. hit_count=3, miss_count=3.
